// File: rtl/doodle_pkg.sv
// rtl/doodle_pkg.sv - shared types and default geometry for the Doodle collision logic
package doodle_pkg;

    typedef logic [10:0] coord_t;

    localparam int NUM_PLAT_DEF = 32;
    localparam int PLAT_W_DEF   = 60;
    localparam int DOODLE_W_DEF = 40;
    localparam int DOODLE_H_DEF = 40;
    localparam int LAND_TOL_DEF = 8;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} scan_state_t;

endpackage

// File: rtl/platform_hit_cmp.sv
// rtl/platform_hit_cmp.sv - combinational landing test of the Doodle's feet against one platform top
module platform_hit_cmp
    import doodle_pkg::*;
#(
    parameter int PLAT_W   = PLAT_W_DEF,
    parameter int DOODLE_W = DOODLE_W_DEF,
    parameter int DOODLE_H = DOODLE_H_DEF,
    parameter int LAND_TOL = LAND_TOL_DEF
)(
    input  coord_t     Doodle_X,
    input  coord_t     Doodle_Y,
    input  logic       Doodle_Falling,
    input  coord_t     Plat_X,
    input  coord_t     Plat_Y,
    output logic       hit
);

    localparam logic [11:0] PW = 12'(PLAT_W);
    localparam logic [11:0] DW = 12'(DOODLE_W);
    localparam logic [11:0] DH = 12'(DOODLE_H);
    localparam logic [11:0] LT = 12'(LAND_TOL);

    // One extra bit keeps every sum below from wrapping for 11-bit coordinates.
    logic [11:0] dx, dy, px, py, feet;

    always_comb begin
        dx   = {1'b0, Doodle_X};
        dy   = {1'b0, Doodle_Y};
        px   = {1'b0, Plat_X};
        py   = {1'b0, Plat_Y};
        feet = dy + DH;
        hit  = Doodle_Falling
            && (dx + DW > px) && (dx < px + PW)
            && (feet >= py) && (feet < py + LT);
    end

endmodule

// File: rtl/platform_collide_scan.sv
// rtl/platform_collide_scan.sv - per-frame platform table scan reporting the first landing hit; Land_Count under PLATFORM_LAND_COUNT_EN
module platform_collide_scan
    import doodle_pkg::*;
#(
    parameter int NUM_PLAT = NUM_PLAT_DEF,
    parameter int PLAT_W   = PLAT_W_DEF,
    parameter int DOODLE_W = DOODLE_W_DEF,
    parameter int DOODLE_H = DOODLE_H_DEF,
    parameter int LAND_TOL = LAND_TOL_DEF,
    localparam int IW      = $clog2(NUM_PLAT)
)(
    input  logic          CLK,
    input  logic          Reset_n,
    input  logic          Frame_Start,
    input  coord_t        Doodle_X,
    input  coord_t        Doodle_Y,
    input  logic          Doodle_Falling,
    output logic          Plat_Rd_En,
    output logic [IW-1:0] Plat_Rd_Idx,
    input  coord_t        Plat_X,
    input  coord_t        Plat_Y,
    output logic          Busy,
    output logic          Land_Valid,
    output logic [IW-1:0] Land_Idx,
    output coord_t        Land_Y
`ifdef PLATFORM_LAND_COUNT_EN
    ,
    output logic [15:0]   Land_Count
`endif
);

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_PLAT - 1);

    scan_state_t   state, state_nxt;
    logic [IW-1:0] scan_idx;
    logic [IW-1:0] eval_idx;
    logic          eval_pend;
    logic          hit_flag;
    logic          hit;
    coord_t        lat_x, lat_y;
    logic          lat_fall;

    platform_hit_cmp #(
        .PLAT_W   (PLAT_W),
        .DOODLE_W (DOODLE_W),
        .DOODLE_H (DOODLE_H),
        .LAND_TOL (LAND_TOL)
    ) u_hit_cmp (
        .Doodle_X       (lat_x),
        .Doodle_Y       (lat_y),
        .Doodle_Falling (lat_fall),
        .Plat_X         (Plat_X),
        .Plat_Y         (Plat_Y),
        .hit            (hit)
    );

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            scan_idx  <= '0;
            eval_idx  <= '0;
            eval_pend <= 1'b0;
            hit_flag  <= 1'b0;
            lat_x     <= '0;
            lat_y     <= '0;
            lat_fall  <= 1'b0;
            Land_Idx  <= '0;
            Land_Y    <= '0;
        end else begin
            state     <= state_nxt;
            // Table data lags the strobe by one cycle, so evaluation tracks the previous index.
            eval_pend <= (state == SCAN);
            eval_idx  <= scan_idx;
            if (state == IDLE && Frame_Start) begin
                lat_x    <= Doodle_X;
                lat_y    <= Doodle_Y;
                lat_fall <= Doodle_Falling;
                hit_flag <= 1'b0;
                Land_Idx <= '0;
                Land_Y   <= '0;
                scan_idx <= '0;
            end else if (state == SCAN) begin
                scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
            end
            if (eval_pend && hit && !hit_flag) begin
                hit_flag <= 1'b1;
                Land_Idx <= eval_idx;
                Land_Y   <= Plat_Y;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        Plat_Rd_En  = 1'b0;
        Plat_Rd_Idx = '0;
        Busy        = (state != IDLE);
        Land_Valid  = 1'b0;
        case (state)
            IDLE:  if (Frame_Start) state_nxt = SCAN;
            SCAN: begin
                Plat_Rd_En  = 1'b1;
                Plat_Rd_Idx = scan_idx;
                if (scan_idx == LAST_IDX) state_nxt = DRAIN;
            end
            DRAIN: state_nxt = DONE;
            DONE: begin
                Land_Valid = hit_flag;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef PLATFORM_LAND_COUNT_EN
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n)
            Land_Count <= '0;
        else if (Land_Valid && Land_Count != 16'hFFFF)
            Land_Count <= Land_Count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_platform_collide_scan.sv
// tb/tb_platform_collide_scan.sv - directed table-driven bench for platform_collide_scan
module tb_platform_collide_scan;
    import doodle_pkg::*;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Frame_Start = 1'b0;
    coord_t      Doodle_X = '0, Doodle_Y = '0;
    logic        Doodle_Falling = 1'b0;
    logic        Plat_Rd_En;
    logic [4:0]  Plat_Rd_Idx;
    coord_t      Plat_X = '0, Plat_Y = '0;
    logic        Busy, Land_Valid;
    logic [4:0]  Land_Idx;
    coord_t      Land_Y;
`ifdef PLATFORM_LAND_COUNT_EN
    logic [15:0] Land_Count;
`endif

    int checks = 0;
    int errors = 0;

    coord_t tbl_x [32];
    coord_t tbl_y [32];

    platform_collide_scan dut (
        .CLK            (CLK),
        .Reset_n        (Reset_n),
        .Frame_Start    (Frame_Start),
        .Doodle_X       (Doodle_X),
        .Doodle_Y       (Doodle_Y),
        .Doodle_Falling (Doodle_Falling),
        .Plat_Rd_En     (Plat_Rd_En),
        .Plat_Rd_Idx    (Plat_Rd_Idx),
        .Plat_X         (Plat_X),
        .Plat_Y         (Plat_Y),
        .Busy           (Busy),
        .Land_Valid     (Land_Valid),
        .Land_Idx       (Land_Idx),
        .Land_Y         (Land_Y)
`ifdef PLATFORM_LAND_COUNT_EN
        ,
        .Land_Count     (Land_Count)
`endif
    );

    always #5 CLK = ~CLK;

    // Platform table with one-cycle read latency.
    always @(posedge CLK) begin
        if (Plat_Rd_En) begin
            Plat_X <= tbl_x[Plat_Rd_Idx];
            Plat_Y <= tbl_y[Plat_Rd_Idx];
        end
    end

    typedef struct {
        string      name;
        logic [4:0] p1_idx;
        coord_t     p1_x, p1_y;
        logic       p2_en;
        logic [4:0] p2_idx;
        coord_t     p2_x, p2_y;
        coord_t     dx, dy;
        logic       fall;
        logic       exp_valid;
        logic [4:0] exp_idx;
        coord_t     exp_y;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_table();
        for (int i = 0; i < 32; i++) begin
            tbl_x[i] = '0;
            tbl_y[i] = '0;
        end
    endtask

    // Runs one frame; returns pulse count, cycle of first pulse, and captured idx/y.
    task automatic run_frame(input coord_t dx, input coord_t dy, input logic fall,
                             output int pulses, output int first_cyc,
                             output logic [4:0] idx, output coord_t ly, output logic busy_after);
        pulses = 0; first_cyc = -1; idx = '0; ly = '0; busy_after = 1'b1;
        @(posedge CLK); #1;
        Doodle_X = dx; Doodle_Y = dy; Doodle_Falling = fall; Frame_Start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge CLK); #1;
            if (cyc == 1) begin
                Frame_Start = 1'b0;
                Doodle_X = 11'd700; Doodle_Y = 11'd5; Doodle_Falling = 1'b0;
            end
            if (Land_Valid) begin
                pulses++;
                if (first_cyc < 0) first_cyc = cyc;
            end
            if (cyc == 36) busy_after = Busy;
        end
        idx = Land_Idx;
        ly  = Land_Y;
    endtask

    int          pulses, first_cyc;
    logic [4:0]  got_idx;
    coord_t      got_y;
    logic        busy_after;
    logic        seen_bad;

    initial begin
        vecs[0] = '{"single",     5'd5,  11'd100, 11'd300, 1'b0, 5'd0, 11'd0,   11'd0,   11'd110, 11'd262, 1'b1, 1'b1, 5'd5,  11'd300};
        vecs[1] = '{"two_hits",   5'd3,  11'd100, 11'd300, 1'b1, 5'd9, 11'd100, 11'd298, 11'd110, 11'd262, 1'b1, 1'b1, 5'd3,  11'd300};
        vecs[2] = '{"right_edge", 5'd5,  11'd100, 11'd300, 1'b0, 5'd0, 11'd0,   11'd0,   11'd160, 11'd262, 1'b1, 1'b0, 5'd0,  11'd0};
        vecs[3] = '{"left_edge",  5'd5,  11'd100, 11'd300, 1'b0, 5'd0, 11'd0,   11'd0,   11'd61,  11'd262, 1'b1, 1'b1, 5'd5,  11'd300};
        vecs[4] = '{"feet_308",   5'd5,  11'd100, 11'd300, 1'b0, 5'd0, 11'd0,   11'd0,   11'd110, 11'd268, 1'b1, 1'b0, 5'd0,  11'd0};
        vecs[5] = '{"not_fall",   5'd5,  11'd100, 11'd300, 1'b0, 5'd0, 11'd0,   11'd0,   11'd110, 11'd262, 1'b0, 1'b0, 5'd0,  11'd0};
        vecs[6] = '{"feet_300",   5'd5,  11'd100, 11'd300, 1'b0, 5'd0, 11'd0,   11'd0,   11'd110, 11'd260, 1'b1, 1'b1, 5'd5,  11'd300};
        vecs[7] = '{"last_entry", 5'd31, 11'd100, 11'd300, 1'b0, 5'd0, 11'd0,   11'd0,   11'd110, 11'd262, 1'b1, 1'b1, 5'd31, 11'd300};
        vecs[8] = '{"first_ent",  5'd0,  11'd400, 11'd500, 1'b0, 5'd0, 11'd0,   11'd0,   11'd380, 11'd465, 1'b1, 1'b1, 5'd0,  11'd500};

        clear_table();
        repeat (3) @(posedge CLK);
        #1 Reset_n = 1'b1;

        // Idle after reset: nothing moves.
        seen_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge CLK); #1;
            if (Land_Valid || Busy || Plat_Rd_En || Plat_Rd_Idx != 0 || Land_Idx != 0 || Land_Y != 0)
                seen_bad = 1'b1;
        end
        chk("reset_idle", {31'd0, seen_bad}, 32'd0);
`ifdef PLATFORM_LAND_COUNT_EN
        chk("count_reset", {16'd0, Land_Count}, 32'd0);
`endif

        for (int v = 0; v < 9; v++) begin
            clear_table();
            tbl_x[vecs[v].p1_idx] = vecs[v].p1_x;
            tbl_y[vecs[v].p1_idx] = vecs[v].p1_y;
            if (vecs[v].p2_en) begin
                tbl_x[vecs[v].p2_idx] = vecs[v].p2_x;
                tbl_y[vecs[v].p2_idx] = vecs[v].p2_y;
            end
            run_frame(vecs[v].dx, vecs[v].dy, vecs[v].fall, pulses, first_cyc, got_idx, got_y, busy_after);
            chk({vecs[v].name, "_pulses"}, pulses, vecs[v].exp_valid ? 32'd1 : 32'd0);
            if (vecs[v].exp_valid) chk({vecs[v].name, "_latency"}, first_cyc, 32'd34);
            chk({vecs[v].name, "_idx"}, {27'd0, got_idx}, {27'd0, vecs[v].exp_idx});
            chk({vecs[v].name, "_y"}, {21'd0, got_y}, {21'd0, vecs[v].exp_y});
            chk({vecs[v].name, "_busy_end"}, {31'd0, busy_after}, 32'd0);
        end

        // Re-pulse mid-scan and in the DONE cycle: both ignored.
        clear_table();
        tbl_x[5] = 11'd100; tbl_y[5] = 11'd300;
        pulses = 0; first_cyc = -1; seen_bad = 1'b0;
        @(posedge CLK); #1;
        Doodle_X = 11'd110; Doodle_Y = 11'd262; Doodle_Falling = 1'b1; Frame_Start = 1'b1;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            @(posedge CLK); #1;
            Frame_Start = (cyc == 10 || cyc == 34);
            if (Land_Valid) begin
                pulses++;
                if (first_cyc < 0) first_cyc = cyc;
            end
            if (cyc >= 35 && Busy) seen_bad = 1'b1;
        end
        Frame_Start = 1'b0;
        chk("repulse_pulses", pulses, 32'd1);
        chk("repulse_latency", first_cyc, 32'd34);
        chk("done_start_ignored", {31'd0, seen_bad}, 32'd0);

        // Reset asserted at cycle 10 of a hitting frame.
        pulses = 0;
        @(posedge CLK); #1;
        Frame_Start = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(posedge CLK); #1;
            Frame_Start = 1'b0;
        end
        chk("pre_reset_busy", {31'd0, Busy}, 32'd1);
        Reset_n = 1'b0;
        #1;
        chk("reset_busy", {31'd0, Busy}, 32'd0);
        chk("reset_rd_en", {31'd0, Plat_Rd_En}, 32'd0);
        @(posedge CLK); #1;
        Reset_n = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(posedge CLK); #1;
            if (Land_Valid) pulses++;
        end
        chk("reset_no_pulse", pulses, 32'd0);
        chk("reset_busy_after", {31'd0, Busy}, 32'd0);

`ifdef PLATFORM_LAND_COUNT_EN
        chk("count_after_reset", {16'd0, Land_Count}, 32'd0);
        for (int f = 0; f < 3; f++)
            run_frame(11'd110, 11'd262, 1'b1, pulses, first_cyc, got_idx, got_y, busy_after);
        chk("count_three", {16'd0, Land_Count}, 32'd3);
        Reset_n = 1'b0;
        #1;
        chk("count_cleared", {16'd0, Land_Count}, 32'd0);
        Reset_n = 1'b1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
